// File: rtl/handshake_pkg.sv
// handshake_pkg: shared states and defaults for the req/ack CDC handshake
package handshake_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_HOLD, RX_ACK} rx_state_t;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_SYNC_STAGES = 2;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: single-bit flop chain for bringing a level across clock domains
module sync_ff #(
  parameter int STAGES = handshake_pkg::DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clk)
    chain <= rst ? '0 : {chain[STAGES-2:0], d};
  assign q = chain[STAGES-1];
endmodule

// File: rtl/handshake_receiver_fsm.sv
// handshake_receiver_fsm: destination end of a four-phase req/ack handshake feeding a valid/ready consumer
module handshake_receiver_fsm
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   dest_clk,
  input  logic                   dest_reset,
  input  logic                   req,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   ack,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic [COUNT_WIDTH-1:0] xfer_count
);
  rx_state_t state, state_n;
  logic req_s, load, accept;
  sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk(dest_clk),
    .rst(dest_reset),
    .d(req),
    .q(req_s)
  );
  always_comb begin
    load    = state == RX_IDLE && req_s;
    accept  = state == RX_HOLD && data_ready;
    state_n = state == RX_IDLE ? (req_s ? RX_HOLD : RX_IDLE) :
              state == RX_HOLD ? (data_ready ? RX_ACK : RX_HOLD) :
              (req_s ? RX_ACK : RX_IDLE);
  end
  // ack and data_valid are flops decoded from the next state so they never glitch
  always_ff @(posedge dest_clk) begin
    if (dest_reset) begin
      state      <= RX_IDLE;
      ack        <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      xfer_count <= '0;
    end else begin
      state      <= state_n;
      ack        <= state_n == RX_ACK;
      data_valid <= state_n == RX_HOLD;
      if (load) data_out <= data_in;
      if (accept) xfer_count <= xfer_count + COUNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_handshake_receiver_fsm.sv
// tb_handshake_receiver_fsm: scenario tasks plus a randomized sender/consumer against a queue model
module tb_handshake_receiver_fsm;
  localparam int DW = 32;
  localparam int SS = 2;
  logic dest_clk = 0, src_clk = 0, dest_reset = 1, req = 0, data_ready = 0;
  logic [DW-1:0] data_in = '0, data_out, data_out_w;
  logic ack, data_valid, ack_w, data_valid_w;
  logic [15:0] xfer_count;
  logic [2:0] cnt_w;
  int half = 5, checks = 0, failures = 0, exp_cnt = 0;

  always #(half) dest_clk = ~dest_clk;
  always #10 src_clk = ~src_clk;

  handshake_receiver_fsm #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .COUNT_WIDTH(16)) dut (
    .dest_clk(dest_clk), .dest_reset(dest_reset), .req(req), .data_in(data_in),
    .ack(ack), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .xfer_count(xfer_count));

  // narrow counter copy shares every input so wraparound is exercised within a short run
  handshake_receiver_fsm #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .COUNT_WIDTH(3)) dut_w (
    .dest_clk(dest_clk), .dest_reset(dest_reset), .req(req), .data_in(data_in),
    .ack(ack_w), .data_out(data_out_w), .data_valid(data_valid_w),
    .data_ready(data_ready), .xfer_count(cnt_w));

  task automatic tick();
    @(posedge dest_clk);
    #1;
  endtask

  task automatic test_reset();
    dest_reset = 1; req = 1; data_ready = 1; data_in = $urandom;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({ack, data_valid, data_out, xfer_count} !== '0) begin
        failures++;
        $display("FAIL reset ack=%b valid=%b data=%h cnt=%h required all zero", ack, data_valid, data_out, xfer_count);
      end
    end
    dest_reset = 0; req = 0; data_ready = 0; exp_cnt = 0;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    data_in = 32'hABAB_CDCD; data_ready = 1; req = 1;
    for (int i = 0; i < SS; i++) begin
      tick();
      checks++;
      if (data_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid edge=%0d got=%b required=0", i, data_valid); end
    end
    tick();
    checks++;
    if (data_valid !== 1'b1 || data_out !== 32'hABAB_CDCD || ack !== 1'b0) begin
      failures++; $display("FAIL basic_capture valid=%b data=%h ack=%b required 1/ababcdcd/0", data_valid, data_out, ack);
    end
    tick();
    exp_cnt++;
    checks++;
    if (ack !== 1'b1 || data_valid !== 1'b0 || xfer_count !== 16'(exp_cnt)) begin
      failures++; $display("FAIL basic_ack ack=%b valid=%b cnt=%0d required 1/0/%0d", ack, data_valid, xfer_count, exp_cnt);
    end
    req = 0;
    for (int i = 0; i < SS; i++) begin
      tick();
      checks++;
      if (ack !== 1'b1) begin failures++; $display("FAIL basic_ack_hold edge=%0d got=%b required=1", i, ack); end
    end
    tick();
    checks++;
    if (ack !== 1'b0 || xfer_count !== 16'd1) begin
      failures++; $display("FAIL basic_ack_fall ack=%b cnt=%0d required 0/1", ack, xfer_count);
    end
    data_ready = 0;
  endtask

  task automatic test_backpressure();
    data_in = 32'h1234_5678; data_ready = 0; req = 1;
    repeat (SS + 1) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (data_valid !== 1'b1 || ack !== 1'b0 || data_out !== 32'h1234_5678) begin
        failures++; $display("FAIL bp_hold cyc=%0d valid=%b ack=%b data=%h required 1/0/12345678", i, data_valid, ack, data_out);
      end
    end
    data_ready = 1;
    tick();
    exp_cnt++;
    checks++;
    if (ack !== 1'b1 || xfer_count !== 16'(exp_cnt)) begin
      failures++; $display("FAIL bp_release ack=%b cnt=%0d required 1/%0d", ack, xfer_count, exp_cnt);
    end
    data_ready = 0; req = 0;
    repeat (SS + 1) tick();
    checks++;
    if (ack !== 1'b0 || data_valid !== 1'b0) begin
      failures++; $display("FAIL bp_idle ack=%b valid=%b required 0/0", ack, data_valid);
    end
  endtask

  task automatic test_ready_ignored();
    logic [DW-1:0] w;
    data_ready = 1; req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (data_valid !== 1'b0 || xfer_count !== 16'(exp_cnt)) begin
        failures++; $display("FAIL idle_ready valid=%b cnt=%0d required 0/%0d", data_valid, xfer_count, exp_cnt);
      end
    end
    w = $urandom; data_in = w; data_ready = 0; req = 1;
    repeat (SS + 1) tick();
    data_ready = 1;
    tick();
    exp_cnt++;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (ack !== 1'b1 || data_valid !== 1'b0 || xfer_count !== 16'(exp_cnt) || data_out !== w) begin
        failures++; $display("FAIL ack_ready ack=%b valid=%b cnt=%0d data=%h required 1/0/%0d/%h", ack, data_valid, xfer_count, data_out, exp_cnt, w);
      end
    end
    req = 0; data_in = ~w;
    repeat (SS + 1) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ack !== 1'b0 || data_out !== w || xfer_count !== 16'(exp_cnt)) begin
        failures++; $display("FAIL after_ack ack=%b data=%h cnt=%0d required 0/%h/%0d", ack, data_out, xfer_count, w, exp_cnt);
      end
    end
    data_ready = 0;
  endtask

  task automatic test_req_drop();
    logic [DW-1:0] w;
    w = $urandom; data_in = w; data_ready = 0; req = 1;
    repeat (SS + 1) tick();
    req = 0;
    repeat (SS) tick();
    checks++;
    if (data_valid !== 1'b1 || ack !== 1'b0 || data_out !== w) begin
      failures++; $display("FAIL drop_hold valid=%b ack=%b data=%h required 1/0/%h", data_valid, ack, data_out, w);
    end
    data_ready = 1;
    tick();
    exp_cnt++;
    checks++;
    if (ack !== 1'b1 || data_valid !== 1'b0 || xfer_count !== 16'(exp_cnt)) begin
      failures++; $display("FAIL drop_ack ack=%b valid=%b cnt=%0d required 1/0/%0d", ack, data_valid, xfer_count, exp_cnt);
    end
    data_ready = 0;
    tick();
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL drop_ack_pulse ack=%b required 0", ack); end
    repeat (3) tick();
    checks++;
    if (data_valid !== 1'b0 || data_out !== w) begin
      failures++; $display("FAIL drop_no_recapture valid=%b data=%h required 0/%h", data_valid, data_out, w);
    end
  endtask

  task automatic test_reset_mid();
    data_in = 32'hDEAD_BEEF; data_ready = 0; req = 1;
    repeat (SS + 1) tick();
    checks++;
    if (data_valid !== 1'b1 || data_out !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL mid_hold valid=%b data=%h required 1/deadbeef", data_valid, data_out);
    end
    dest_reset = 1; req = 0;
    tick();
    checks++;
    if ({ack, data_valid, data_out, xfer_count} !== '0 || cnt_w !== 3'd0) begin
      failures++; $display("FAIL mid_reset ack=%b valid=%b data=%h cnt=%h required all zero", ack, data_valid, data_out, xfer_count);
    end
    tick();
    dest_reset = 0; exp_cnt = 0; data_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ack !== 1'b0 || data_valid !== 1'b0 || xfer_count !== 16'd0) begin
        failures++; $display("FAIL mid_after ack=%b valid=%b cnt=%0d required 0/0/0", ack, data_valid, xfer_count);
      end
    end
    data_ready = 0;
  endtask

  task automatic test_random(input int n);
    logic [DW-1:0] q[$];
    logic [DW-1:0] word, pd;
    int sent = 0, gap = 0, phase = 0;
    bit acc, pv;
    for (int c = 0; c < 3000 && !(sent == n && phase == 0 && q.size() == 0); c++) begin
      if (phase == 0) begin
        if (sent < n && gap == 0) begin
          data_in = $urandom; q.push_back(data_in); req = 1; phase = 1; sent++;
        end else if (gap > 0) gap--;
      end else if (phase == 1) begin
        if (ack) begin req = 0; phase = 2; end
      end else if (!ack) begin
        phase = 0; gap = $urandom_range(0, 3);
      end
      data_ready = 1'($urandom_range(0, 1));
      acc = data_valid && data_ready; word = data_out; pv = data_valid; pd = data_out;
      tick();
      if (acc) begin
        checks++;
        if (q.size() == 0 || word !== q[0]) begin
          failures++; $display("FAIL rand_word got=%h required=%h", word, q.size() ? q[0] : '0);
        end
        if (q.size() > 0) void'(q.pop_front());
        exp_cnt++;
      end
      checks++;
      if (xfer_count !== 16'(exp_cnt) || cnt_w !== 3'(exp_cnt)) begin
        failures++; $display("FAIL rand_count cnt=%0d narrow=%0d required %0d/%0d", xfer_count, cnt_w, 16'(exp_cnt), 3'(exp_cnt));
      end
      checks++;
      if ((pv && data_valid && data_out !== pd) || (ack && data_valid) || ack_w !== ack || data_out_w !== data_out || data_valid_w !== data_valid) begin
        failures++; $display("FAIL rand_outputs ack=%b valid=%b data=%h prev=%h", ack, data_valid, data_out, pd);
      end
    end
    checks++;
    if (sent != n || q.size() != 0 || phase != 0) begin
      failures++; $display("FAIL rand_complete sent=%0d pending=%0d required %0d/0", sent, q.size(), n);
    end
    req = 0; data_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words[2];
    logic [DW-1:0] got[$];
    bit timeout = 0;
    words[0] = 32'hA5A5_A5A5; words[1] = 32'hA1B2_C3D4;
    half = 62;
    repeat (2) tick();
    fork
      begin
        for (int w = 0; w < 2; w++) begin
          @(posedge src_clk);
          data_in = words[w]; req = 1;
          for (int c = 0; c < 400 && !ack; c++) @(posedge src_clk);
          if (!ack) timeout = 1;
          req = 0;
          for (int c = 0; c < 400 && ack; c++) @(posedge src_clk);
          if (ack) timeout = 1;
        end
      end
      begin
        logic [DW-1:0] pd, word;
        bit pv, acc;
        for (int c = 0; c < 40; c++) begin
          data_ready = 1'($urandom_range(0, 1));
          acc = data_valid && data_ready; word = data_out; pv = data_valid; pd = data_out;
          tick();
          if (acc) begin got.push_back(word); exp_cnt++; end
          checks++;
          if (pv && data_valid && data_out !== pd) begin
            failures++; $display("FAIL b2b_stable data=%h prev=%h", data_out, pd);
          end
        end
      end
    join
    checks++;
    if (timeout || got.size() != 2 || xfer_count !== 16'(exp_cnt)) begin
      failures++; $display("FAIL b2b_count timeout=%b words=%0d cnt=%0d required 0/2/%0d", timeout, got.size(), xfer_count, 16'(exp_cnt));
    end else begin
      checks++;
      if (got[0] !== words[0] || got[1] !== words[1]) begin
        failures++; $display("FAIL b2b_order got=%h,%h required %h,%h", got[0], got[1], words[0], words[1]);
      end
    end
    data_ready = 0;
    half = 5;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ready_ignored();
    test_req_drop();
    test_reset_mid();
    test_random(40);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
